alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// one operation in flight, registered result held until the owner consumes it.
module alu_arbiter #(
    parameter int XLEN   = 32,
    parameter int MAX_OP = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [3:0]      req0_op,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    output logic            rsp1_valid,
    input  logic            rsp0_ready,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zflag
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              grantee, last_grant;
    logic              grant, accept, rsp_fire, op_err;

    // grant = index of the winning requester; ties go to the one not served last
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign rsp0_valid = (state == RESP) && !grantee;
    assign rsp1_valid = (state == RESP) && grantee;
    assign rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign op_err   = {28'd0, op_q} > 32'(MAX_OP);
    assign alu_rs1  = a_q;
    assign alu_rs2  = b_q;
    assign alu_ctrl = op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            grantee    <= 1'b0;
            last_grant <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= grant ? req1_op : req0_op;
                a_q        <= grant ? req1_a  : req0_a;
                b_q        <= grant ? req1_b  : req0_b;
                grantee    <= grant;
                last_grant <= grant;
            end
            // Unsupported codes never reach the requester as a real result
            if (state == EXEC) begin
                if (op_err) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                    rsp_err    <= 1'b1;
                end else begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zflag;
                    rsp_err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU attached to the
// alu_* ports; expected results are hand-computed constants.
module tb_alu_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]      req0_op, req1_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero, rsp_err;
    logic [XLEN-1:0] alu_rs1, alu_rs2, alu_result;
    logic [3:0]      alu_ctrl;
    logic            alu_zflag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN), .MAX_OP(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zflag(alu_zflag)
    );

    // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'd0: alu_result = alu_rs1 + alu_rs2;
            4'd1: alu_result = alu_rs1 - alu_rs2;
            4'd2: alu_result = alu_rs1 & alu_rs2;
            4'd3: alu_result = alu_rs1 | alu_rs2;
            4'd4: alu_result = alu_rs1 ^ alu_rs2;
            4'd5: alu_result = alu_rs1 << alu_rs2[4:0];
            4'd6: alu_result = alu_rs1 >> alu_rs2[4:0];
            4'd7: alu_result = $unsigned($signed(alu_rs1) >>> alu_rs2[4:0]);
            4'd8: alu_result = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
            default: alu_result = '0;
        endcase
        alu_zflag = (alu_result == '0);
    end

    typedef struct {
        logic [3:0]      op;
        logic [XLEN-1:0] a, b, res;
        logic            zero, err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'd0,  32'd2, 32'd1, 32'd3, 1'b0, 1'b0};
        tbl[1]  = '{4'd1,  32'd2, 32'd1, 32'd1, 1'b0, 1'b0};
        tbl[2]  = '{4'd2,  32'd2, 32'd1, 32'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'd3,  32'd2, 32'd1, 32'd3, 1'b0, 1'b0};
        tbl[4]  = '{4'd4,  32'd2, 32'd1, 32'd3, 1'b0, 1'b0};
        tbl[5]  = '{4'd5,  32'd2, 32'd1, 32'd4, 1'b0, 1'b0};
        tbl[6]  = '{4'd6,  32'd2, 32'd1, 32'd1, 1'b0, 1'b0};
        tbl[7]  = '{4'd7,  32'd2, 32'd1, 32'd1, 1'b0, 1'b0};
        tbl[8]  = '{4'd8,  32'd2, 32'd1, 32'd0, 1'b1, 1'b0};
        tbl[9]  = '{4'd9,  32'd2, 32'd1, 32'd0, 1'b0, 1'b1};
        tbl[10] = '{4'd15, 32'd2, 32'd1, 32'd0, 1'b0, 1'b1};
        tbl[11] = '{4'd1,  32'd2, 32'd2, 32'd0, 1'b1, 1'b0};

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 4'd0; req1_op = 4'd0;
        req0_a = 32'd2; req0_b = 32'd1; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state, with a request already pending
        #2;
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_rsp_valids", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_rsp_regs", 64'({rsp_zero, rsp_err}), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        tick();
        rst = 1'b0;
        #1;

        // Single request on req0; a changes after acceptance
        chk("single_ready", 64'({req0_ready, req1_ready}), 64'b10);
        tick();
        req0_valid = 1'b0;
        req0_a = 32'd100;
        #1;
        chk("single_t1_rsp0", 64'(rsp0_valid), 64'd0);
        chk("single_t1_rs1", 64'(alu_rs1), 64'd2);
        tick();
        chk("single_t2_rsp0", 64'(rsp0_valid), 64'd1);
        chk("single_t2_result", 64'(rsp_result), 64'd3);
        chk("single_t2_err", 64'(rsp_err), 64'd0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("single_done", 64'(rsp0_valid), 64'd0);

        // Op sweep on req1
        for (int i = 0; i < 12; i++) begin
            req1_valid = 1'b1;
            req1_op = tbl[i].op; req1_a = tbl[i].a; req1_b = tbl[i].b;
            #1;
            chk($sformatf("sweep%0d_ready", i), 64'({req0_ready, req1_ready}), 64'b01);
            tick();
            req1_valid = 1'b0;
            req1_op = 4'd0;
            tick();
            chk($sformatf("sweep%0d_valid", i), 64'({rsp0_valid, rsp1_valid}), 64'b01);
            chk($sformatf("sweep%0d_result", i), 64'(rsp_result), 64'(tbl[i].res));
            chk($sformatf("sweep%0d_flags", i), 64'({rsp_zero, rsp_err}),
                64'({tbl[i].zero, tbl[i].err}));
            rsp1_ready = 1'b1;
            tick();
            rsp1_ready = 1'b0;
        end

        // Backpressure on req1 while req0 waits; stray rsp0_ready is ignored
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd10; req1_b = 32'd20;
        #1;
        chk("bp_accept", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd9; req0_b = 32'd4;
        rsp0_ready = 1'b1;
        #1;
        chk("bp_exec_req0_ready", 64'(req0_ready), 64'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), 64'({rsp0_valid, rsp1_valid}), 64'b01);
            chk($sformatf("bp%0d_result", c), 64'(rsp_result), 64'd30);
            chk($sformatf("bp%0d_req0_ready", c), 64'(req0_ready), 64'd0);
            tick();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("bp_req0_served", 64'({req0_ready, req1_ready}), 64'b10);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("bp_req0_result", 64'(rsp_result), 64'd5);
        chk("bp_req0_valid", 64'(rsp0_valid), 64'd1);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Async reset in EXEC aborts the operation
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd6; req0_b = 32'd1;
        tick();
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rsp_result", 64'(rsp_result), 64'd0);
        chk("ar_ctrl_rs1", 64'({alu_ctrl, alu_rs1}), 64'd0);
        chk("ar_valids", 64'({rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ar_no_rsp%0d", c), 64'({rsp0_valid, rsp1_valid}), 64'd0);
            tick();
        end

        // Simultaneous contest held valid: grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd5; req1_b = 32'd3;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk($sformatf("rr%0d_ready", g), 64'({req0_ready, req1_ready}),
                (g % 2 == 0) ? 64'b10 : 64'b01);
            tick();
            chk($sformatf("rr%0d_exec_ready", g), 64'({req0_ready, req1_ready}), 64'd0);
            tick();
            chk($sformatf("rr%0d_valid", g), 64'({rsp0_valid, rsp1_valid}),
                (g % 2 == 0) ? 64'b10 : 64'b01);
            chk($sformatf("rr%0d_result", g), 64'(rsp_result),
                (g % 2 == 0) ? 64'd8 : 64'd2);
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
